// File: rtl/sr_loader_pkg.sv
// ============================================================================
// Module  : sr_loader_pkg
// Brief   : Shared state encoding and default sizing for the SR register loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sr_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      HOLD  = 2'd2,
      CHECK = 2'd3
   } sr_state_e;

   localparam int SR_WIDTH        = 4;
   localparam int SR_PULSE_CYCLES = 2;
   localparam int SR_HOLD_CYCLES  = 1;

   function automatic int sr_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sr_pulse_timer.sv
// ============================================================================
// Module  : sr_pulse_timer
// Brief   : Loadable saturating down-counter with zero flag, shared by the
//           pulse and settle phases of the loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sr_pulse_timer
   import sr_loader_pkg::*;
#(
   parameter int CW = 2
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   output logic          zero_o
);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/sr_reg_loader.sv
// ============================================================================
// Module  : sr_reg_loader
// Brief   : Turns a valid/ready command into exclusive S/R pulses, a settle
//           window and a done strobe. Readback option: SR_LOADER_READBACK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sr_reg_loader
   import sr_loader_pkg::*;
#(
   parameter int WIDTH        = SR_WIDTH,
   parameter int PULSE_CYCLES = SR_PULSE_CYCLES,
   parameter int HOLD_CYCLES  = SR_HOLD_CYCLES
) (
   input  logic             clk1,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_clr,
   output logic [WIDTH-1:0] s_out,
   output logic [WIDTH-1:0] r_out,
   input  logic [WIDTH-1:0] q_fb,
   output logic             busy,
   output logic             done,
   output logic             mismatch
);

   localparam int C_MAX_CYC = sr_max(PULSE_CYCLES, HOLD_CYCLES);
   localparam int CW        = $clog2(C_MAX_CYC + 1);
   localparam logic [CW-1:0] C_PULSE_LD = CW'((PULSE_CYCLES > 0) ? PULSE_CYCLES - 1 : 0);
   localparam logic [CW-1:0] C_HOLD_LD  = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

   if (PULSE_CYCLES < 1) begin : g_bad_pulse
      $error("sr_reg_loader: PULSE_CYCLES must be >= 1");
   end

   sr_state_e        state_q;
   logic [WIDTH-1:0] target_q;
   logic [WIDTH-1:0] s_q;
   logic [WIDTH-1:0] r_q;
   logic             busy_q;
   logic             done_q;

   logic             w_accept;
   logic             w_tmr_load;
   logic [CW-1:0]    w_tmr_val;
   logic             w_tmr_zero;
   logic [WIDTH-1:0] w_target_d;

   assign w_accept   = (state_q == IDLE) && in_valid;
   assign w_target_d = in_clr ? '0 : in_data;
   assign w_tmr_load = w_accept || ((state_q == DRIVE) && w_tmr_zero && (HOLD_CYCLES > 0));
   assign w_tmr_val  = w_accept ? C_PULSE_LD : C_HOLD_LD;

   sr_pulse_timer #(
      .CW (CW)
   ) u_timer (
      .clk1       (clk1),
      .rst_n      (rst_n),
      .load_i     (w_tmr_load),
      .load_val_i (w_tmr_val),
      .zero_o     (w_tmr_zero)
   );

`ifdef SR_LOADER_READBACK_EN
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("sr_reg_loader: readback needs HOLD_CYCLES >= 1 for settling");
   end

   logic mismatch_q;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         mismatch_q <= 1'b0;
      end else if (w_accept) begin
         mismatch_q <= 1'b0;
      end else if (state_q == CHECK) begin
         mismatch_q <= (q_fb != target_q);
      end
   end

   assign mismatch = mismatch_q;
`else
   logic w_unused_fb;
   assign w_unused_fb = ^{q_fb, target_q};
   assign mismatch    = 1'b0;
`endif

   // S and R are only ever loaded as a value and its complement, or both zero.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         target_q <= '0;
         s_q      <= '0;
         r_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  target_q <= w_target_d;
                  s_q      <= w_target_d;
                  r_q      <= ~w_target_d;
                  busy_q   <= 1'b1;
                  state_q  <= DRIVE;
               end
            end
            DRIVE: begin
               if (w_tmr_zero) begin
                  s_q <= '0;
                  r_q <= '0;
                  if (HOLD_CYCLES == 0) begin
                     state_q <= CHECK;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (w_tmr_zero) begin
                  state_q <= CHECK;
                  done_q  <= 1'b1;
               end
            end
            CHECK: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               s_q     <= '0;
               r_q     <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready = (state_q == IDLE);
   assign s_out    = s_q;
   assign r_out    = r_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_reg_loader.sv
// ============================================================================
// Module  : tb_sr_reg_loader
// Brief   : Self-checking bench for sr_reg_loader with a drive-order scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sr_reg_loader;

   localparam int P = 2;
`ifdef SR_LOADER_READBACK_EN
   localparam int H = 2;
`else
   localparam int H = 1;
`endif

   logic       clk1 = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_clr;
   logic [3:0] s_out;
   logic [3:0] r_out;
   logic [3:0] q_fb;
   logic       busy;
   logic       done;
   logic       mismatch;

   int total = 0;
   int bad   = 0;
   logic [3:0] exp_q[$];
   logic [3:0] mon_e;
   bit         prev_drive = 1'b0;
   bit         in_drive;

   sr_reg_loader #(
      .WIDTH        (4),
      .PULSE_CYCLES (P),
      .HOLD_CYCLES  (H)
   ) dut (
      .clk1     (clk1),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_clr   (in_clr),
      .s_out    (s_out),
      .r_out    (r_out),
      .q_fb     (q_fb),
      .busy     (busy),
      .done     (done),
      .mismatch (mismatch)
   );

   always #5 clk1 = ~clk1;

   // Every cycle: S/R exclusive and either all-driven or all-idle; each new
   // drive phase is popped against the scoreboard.
   always @(negedge clk1) begin
      total++;
      if ((s_out & r_out) !== 4'h0 || !((s_out | r_out) === 4'h0 || (s_out | r_out) === 4'hF)) begin
         bad++;
         $display("FAIL sr_exclusive: s_out=%b r_out=%b", s_out, r_out);
      end
      in_drive = ((s_out | r_out) === 4'hF);
      if (in_drive && !prev_drive) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_drive: s_out=%b r_out=%b with no command pending", s_out, r_out);
         end else begin
            mon_e = exp_q.pop_front();
            if (s_out !== mon_e || r_out !== ~mon_e) begin
               bad++;
               $display("FAIL drive_value: s_out=%b r_out=%b want s=%b r=%b", s_out, r_out, mon_e, ~mon_e);
            end
         end
      end
      prev_drive = in_drive;
   end

   task automatic wait_idle(input string nm);
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk1);
         n++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s_ready_timeout: in_ready=%b after %0d cycles want 1", nm, in_ready, n);
      end
   endtask

   // Present one command for a single cycle; returns at the first DRIVE cycle.
   task automatic issue(input logic [3:0] d, input logic clr);
      wait_idle("issue");
      in_valid = 1'b1;
      in_data  = d;
      in_clr   = clr;
      exp_q.push_back(clr ? 4'h0 : d);
      @(negedge clk1);
      in_valid = 1'b0;
      in_clr   = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] want;
      want = {4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
      @(posedge clk1);
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({s_out, r_out, busy, done, in_ready} !== want || mismatch !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: {s,r,busy,done,rdy}=%b mm=%b want %b mm=0",
                  {s_out, r_out, busy, done, in_ready}, mismatch, want);
      end
      #1 rst_n = 1'b1;
      #1;
      total++;
      if ({s_out, r_out, busy, done, in_ready} !== want || mismatch !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: {s,r,busy,done,rdy}=%b mm=%b want %b mm=0",
                  {s_out, r_out, busy, done, in_ready}, mismatch, want);
      end
      @(negedge clk1);
   endtask

   task automatic test_load();
      logic [3:0]  d = 4'b1010;
      logic [10:0] want;
      issue(d, 1'b0);
      for (int k = 1; k <= P + H + 2; k++) begin
         if (k <= P)              want = {d, ~d, 1'b1, 1'b0, 1'b0};
         else if (k <= P + H)     want = {4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
         else if (k == P + H + 1) want = {4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
         else                     want = {4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
         total++;
         if ({s_out, r_out, busy, done, in_ready} !== want) begin
            bad++;
            $display("FAIL load_t+%0d: {s,r,busy,done,rdy}=%b want %b",
                     k, {s_out, r_out, busy, done, in_ready}, want);
         end
         if (k < P + H + 2) @(negedge clk1);
      end
   endtask

   task automatic test_clear();
      issue(4'b1111, 1'b1);
      for (int k = 1; k <= P; k++) begin
         total++;
         if (s_out !== 4'b0000 || r_out !== 4'b1111) begin
            bad++;
            $display("FAIL clear_drive_%0d: s=%b r=%b want s=0000 r=1111", k, s_out, r_out);
         end
         @(negedge clk1);
      end
      wait_idle("clear");
      in_clr = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk1);
         total++;
         if (busy !== 1'b0 || in_ready !== 1'b1 || (s_out | r_out) !== 4'h0) begin
            bad++;
            $display("FAIL clr_without_valid_%0d: busy=%b rdy=%b s=%b r=%b want 0 1 0000 0000",
                     k, busy, in_ready, s_out, r_out);
         end
      end
      in_clr = 1'b0;
   endtask

   task automatic test_busy_drop();
      issue(4'b0011, 1'b0);
      in_valid = 1'b1;
      in_data  = 4'b0001;
      for (int k = 1; k <= P + H + 1; k++) begin
         total++;
         if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL busy_ready_t+%0d: in_ready=%b want 0", k, in_ready);
         end
         if (k == P + H + 1) in_valid = 1'b0;
         else                @(negedge clk1);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk1);
         total++;
         if (busy !== 1'b0 || (s_out | r_out) !== 4'h0) begin
            bad++;
            $display("FAIL busy_drop_idle_%0d: busy=%b s=%b r=%b want 0 0000 0000", k, busy, s_out, r_out);
         end
      end
   endtask

   task automatic test_back_to_back();
      int accepts = 0;
      int n = 0;
      int c1 = 0;
      int c2 = 0;
      wait_idle("b2b");
      in_valid = 1'b1;
      in_data  = 4'b0110;
      exp_q.push_back(4'b0110);
      exp_q.push_back(4'b0110);
      while (accepts < 2 && n < 40) begin
         if (in_ready === 1'b1) begin
            accepts++;
            if (accepts == 1) c1 = n;
            else              c2 = n;
         end
         @(negedge clk1);
         n++;
      end
      in_valid = 1'b0;
      total++;
      if (accepts != 2 || (c2 - c1) != P + H + 2) begin
         bad++;
         $display("FAIL back_to_back: accepts=%0d spacing=%0d want 2 and %0d", accepts, c2 - c1, P + H + 2);
      end
      wait_idle("b2b_end");
   endtask

   task automatic test_reset_mid_drive();
      issue(4'b1100, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ((s_out | r_out) !== 4'h0 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_drive: s=%b r=%b rdy=%b busy=%b done=%b want 0000 0000 1 0 0",
                  s_out, r_out, in_ready, busy, done);
      end
      #1 rst_n = 1'b1;
      for (int k = 0; k < P + H + 2; k++) begin
         @(negedge clk1);
         total++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_done_%0d: done=%b busy=%b want 0 0", k, done, busy);
         end
      end
   endtask

   task automatic test_readback();
      q_fb = 4'b0100;
      issue(4'b0110, 1'b0);
`ifdef SR_LOADER_READBACK_EN
      repeat (P + H) @(negedge clk1);
      total++;
      if (done !== 1'b1 || mismatch !== 1'b0) begin
         bad++;
         $display("FAIL rb_check_cycle: done=%b mismatch=%b want 1 0", done, mismatch);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk1);
         total++;
         if (mismatch !== 1'b1) begin
            bad++;
            $display("FAIL rb_sticky_%0d: mismatch=%b want 1", k, mismatch);
         end
      end
      q_fb = 4'b0110;
      issue(4'b0110, 1'b0);
      total++;
      if (mismatch !== 1'b0) begin
         bad++;
         $display("FAIL rb_clear_on_accept: mismatch=%b want 0", mismatch);
      end
      repeat (P + H + 1) @(negedge clk1);
      total++;
      if (mismatch !== 1'b0) begin
         bad++;
         $display("FAIL rb_match: mismatch=%b want 0", mismatch);
      end
`else
      for (int k = 1; k <= P + H + 2; k++) begin
         total++;
         if (mismatch !== 1'b0) begin
            bad++;
            $display("FAIL rb_disabled_t+%0d: mismatch=%b want 0", k, mismatch);
         end
         @(negedge clk1);
      end
`endif
      q_fb = 4'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_data  = 4'h0;
      in_clr   = 1'b0;
      q_fb     = 4'h0;
      #1 rst_n = 1'b0;
      @(negedge clk1);
      rst_n = 1'b1;

      test_reset();
      test_load();
      test_clear();
      test_busy_drop();
      test_back_to_back();
      test_reset_mid_drive();
      test_readback();

      wait_idle("final");
      repeat (2) @(negedge clk1);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d commands never driven, want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
